// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor emulator: accepts a trigger pulse and answers with an echo pulse
// whose high width encodes the emulated target distance.
module hcsr04_echo_emulator #(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 10000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int unsigned CntW   = 17;
  localparam int unsigned PrescW = $clog2(CLK_FREQ_MHZ) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StBurst,
    StEchoHi,
    StHoldoff
  } state_e;

  state_e            state_q, state_d;
  logic              trig_meta_q, trig_s_q, trig_prev_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [8:0]        lat_cm_q, lat_cm_d;
  logic              echo_q, echo_d;
  logic              trig_err_q, trig_err_d;
  logic              tick;
  logic              in_range;
  logic [CntW-1:0]   echo_target;

  assign tick        = (presc_q == PrescW'(CLK_FREQ_MHZ - 1));
  assign in_range    = (lat_cm_q != '0) && (32'(lat_cm_q) <= MAX_CM);
  assign echo_target = in_range ? CntW'(lat_cm_q) * CntW'(US_PER_CM) : CntW'(TIMEOUT_US);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_cm_d   = lat_cm_q;
    trig_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a fresh edge starts a measurement; a level held over from HOLDOFF does not.
        if (trig_s_q && !trig_prev_q) begin
          state_d = StTrigHi;
          cnt_d   = '0;
        end
      end
      StTrigHi: begin
        if (!trig_s_q) begin
          cnt_d = '0;
          if (cnt_q >= CntW'(MIN_TRIG_US)) begin
            state_d  = StBurst;
            lat_cm_d = distance_cm;
          end else begin
            state_d    = StIdle;
            trig_err_d = 1'b1;
          end
        end else if (tick && (cnt_q != '1)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBurst: begin
        if (tick) begin
          if (cnt_q == CntW'(BURST_US - 1)) begin
            state_d = StEchoHi;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StEchoHi: begin
        if (tick) begin
          if (cnt_q == echo_target - CntW'(1)) begin
            state_d = StHoldoff;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHoldoff: begin
        if (tick) begin
          if (cnt_q == CntW'(HOLDOFF_US - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Echo register follows the next state so it rises/falls on the state-entry clock.
    echo_d  = (state_d == StEchoHi);
    presc_d = ((state_d != state_q) || tick) ? '0 : presc_q + PrescW'(1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= StIdle;
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      lat_cm_q    <= '0;
      echo_q      <= 1'b0;
      trig_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_meta_q <= trigger;
      trig_s_q    <= trig_meta_q;
      trig_prev_q <= trig_s_q;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      lat_cm_q    <= lat_cm_d;
      echo_q      <= echo_d;
      trig_err_q  <= trig_err_d;
    end
  end

  assign echo     = echo_q;
  assign trig_err = trig_err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed bench for hcsr04_echo_emulator with scaled timing parameters so that the
// out-of-range and max-distance cases stay short.
module tb_hcsr04_echo_emulator;

  localparam int Clk   = 4;
  localparam int MinT  = 10;
  localparam int Burst = 200;
  localparam int Upc   = 2;
  localparam int MaxCm = 400;
  localparam int Tmo   = 900;
  localparam int Hold  = 100;
  localparam int Limit = 10000;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       echo, busy, trig_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int rises    = 0;
  logic echo_prev = 1'b0;

  always #5 clk = ~clk;

  hcsr04_echo_emulator #(
    .CLK_FREQ_MHZ(Clk),
    .MIN_TRIG_US (MinT),
    .BURST_US    (Burst),
    .US_PER_CM   (Upc),
    .MAX_CM      (MaxCm),
    .TIMEOUT_US  (Tmo),
    .HOLDOFF_US  (Hold)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .trigger    (trigger),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  always @(negedge clk) begin
    if (trig_err) err_seen <= err_seen + 1;
    if (echo && !echo_prev) rises <= rises + 1;
    echo_prev <= echo;
  end

  function automatic int echo_us(input int cm);
    return (cm >= 1 && cm <= MaxCm) ? cm * Upc : Tmo;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int us);
    trigger = 1'b1;
    cycles(us * Clk);
    trigger = 1'b0;
  endtask

  task automatic wait_rise(output int d);
    d = 0;
    while (!echo && d < Limit) begin
      @(negedge clk);
      d++;
    end
  endtask

  task automatic wait_fall(output int w);
    w = 0;
    while (echo && w < Limit) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic wait_idle(output int b);
    b = 0;
    while (busy && b < Limit) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic measure(input string tag, input int cm, input int trig_us);
    int d, w, b;
    distance_cm = 9'(cm);
    pulse(trig_us);
    wait_rise(d);
    check({tag, "_dly_in_window"}, int'(d >= (Burst - 1) * Clk && d <= Burst * Clk + Clk + 3), 1);
    wait_fall(w);
    check({tag, "_width"}, w, echo_us(cm) * Clk);
    wait_idle(b);
    check({tag, "_holdoff"}, b, Hold * Clk);
  endtask

  initial begin
    int d, w, b, r0, e0;
    reset_p     = 1'b1;
    trigger     = 1'b0;
    distance_cm = '0;
    cycles(3);
    check("rst_echo", int'(echo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_trig_err", int'(trig_err), 0);
    reset_p = 1'b0;
    cycles(5);

    measure("d100", 100, 12);

    // Short trigger: rejected with exactly one trig_err pulse and no echo.
    e0 = err_seen;
    r0 = rises;
    pulse(5);
    cycles(10 * Clk);
    check("short_err_pulses", err_seen - e0, 1);
    cycles((Burst + 20) * Clk);
    check("short_no_echo", rises - r0, 0);
    check("short_busy", int'(busy), 0);

    measure("d0", 0, 12);
    measure("d450", 450, 12);
    measure("d400", 400, 15);
    measure("d1", 1, 12);

    // Distance change and extra triggers after the latch point are ignored.
    e0 = err_seen;
    r0 = rises;
    distance_cm = 9'd10;
    pulse(12);
    wait_rise(d);
    fork
      wait_fall(w);
      begin
        distance_cm = 9'd300;
        cycles(2);
        pulse(3);
      end
    join
    check("d10_width", w, echo_us(10) * Clk);
    cycles(20 * Clk);
    pulse(12);
    cycles(4);
    pulse(12);
    wait_idle(b);
    cycles((Burst + 20) * Clk);
    check("d10_single_echo", rises - r0, 1);
    check("d10_no_err", err_seen - e0, 0);

    // Asynchronous reset mid-echo aborts immediately.
    distance_cm = 9'd300;
    pulse(12);
    wait_rise(d);
    cycles(400 * Clk);
    check("pre_rst_echo", int'(echo), 1);
    reset_p = 1'b1;
    #1;
    check("rst_mid_echo", int'(echo), 0);
    check("rst_mid_busy", int'(busy), 0);
    @(negedge clk);
    reset_p = 1'b0;
    cycles(4);
    measure("post_rst", 100, 12);

    // Trigger held high across HOLDOFF->IDLE must not start a new measurement.
    r0 = rises;
    distance_cm = 9'd50;
    pulse(12);
    wait_rise(d);
    wait_fall(w);
    check("held_width", w, echo_us(50) * Clk);
    cycles(10 * Clk);
    trigger = 1'b1;
    wait_idle(b);
    cycles((Burst + 50) * Clk);
    check("held_no_retrigger", rises - r0, 1);
    check("held_busy", int'(busy), 0);
    trigger = 1'b0;
    cycles(4);
    measure("fresh_edge", 50, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hcsr04_echo_emulator.md
HCSR04_ECHO_EMULATOR -- requirements
Module: hcsr04_echo_emulator

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 100, meaning clock cycles per microsecond tick.
REQ-002 Parameter MIN_TRIG_US, default 10, meaning minimum trigger high width accepted, in us.
REQ-003 Parameter BURST_US, default 200, meaning delay from accepted trigger fall to echo rise, in us.
REQ-004 Parameter US_PER_CM, default 58, meaning echo high time per centimetre, in us.
REQ-005 Parameter MAX_CM, default 400, meaning largest distance reported as in range.
REQ-006 Parameter TIMEOUT_US, default 38000, meaning echo width for out-of-range distance, in us.
REQ-007 Parameter HOLDOFF_US, default 10000, meaning dead time after echo fall, in us.
REQ-008 Port clk, input, 1, meaning the single system clock; all logic is on the rising edge.
REQ-009 Port reset_p, input, 1, meaning asynchronous active-high reset.
REQ-010 Port trigger, input, 1, meaning asynchronous trigger from the ranging controller.
REQ-011 Port distance_cm, input, 9, meaning emulated target distance, sampled once per measurement.
REQ-012 Port echo, output, 1, meaning echo pulse whose high width encodes distance.
REQ-013 Port busy, output, 1, meaning high in every state except IDLE.
REQ-014 Port trig_err, output, 1, meaning one-cycle pulse when a trigger is rejected for short width.

Function
REQ-015 trigger SHALL pass through a 2-FF synchronizer; all timing below refers to the synchronized signal trig_s.
REQ-016 A free-running us tick SHALL pulse for 1 cycle every CLK_FREQ_MHZ cycles; the prescaler is cleared to 0 on any FSM state change.
REQ-017 The FSM SHALL have exactly 5 states: IDLE, TRIG_HI, BURST, ECHO_HI, HOLDOFF.
REQ-018 IDLE: on trig_s rising edge -> TRIG_HI, with the width counter cleared.
REQ-019 TRIG_HI: count ticks while trig_s is high; on trig_s fall with count >= MIN_TRIG_US -> BURST and latch distance_cm; with count < MIN_TRIG_US -> IDLE and pulse trig_err.
REQ-020 TRIG_HI width counter SHALL saturate at its maximum and never wrap, so a trigger held high indefinitely stays in TRIG_HI.
REQ-021 BURST: after BURST_US ticks -> ECHO_HI; echo rises on the same clock as the state entry.
REQ-022 The echo width target SHALL be latched_cm*US_PER_CM ticks (at least 16-bit product, no truncation) when 1 <= latched_cm <= MAX_CM, else TIMEOUT_US ticks (covers 0 and > MAX_CM).
REQ-023 ECHO_HI: echo is held high until the tick count equals the width target -> HOLDOFF, with echo low on state entry.
REQ-024 HOLDOFF: after HOLDOFF_US ticks -> IDLE.
REQ-025 Trigger edges in BURST, ECHO_HI and HOLDOFF SHALL be ignored, with no trig_err and no retrigger.
REQ-026 A trigger already high on return to IDLE SHALL NOT start a measurement; only a fresh rising edge starts one.
REQ-027 distance_cm changes after the latch point SHALL NOT affect the current echo width.
REQ-028 echo and trig_err SHALL be registered outputs, glitch-free.

Reset
REQ-029 reset_p SHALL asynchronously force: state=IDLE, echo=0, busy=0, trig_err=0, synchronizer=0, all counters=0, latched distance=0.
REQ-030 Reset asserted mid-measurement SHALL abort immediately, with echo low in the same cycle; after release a fresh trigger edge is required.

Verification (CLK_FREQ_MHZ=10, HOLDOFF_US=100 overrides allowed)
REQ-031 distance_cm=100, trigger high 12 us -> echo rises 200 us (±1 tick + 3 clk) after trigger fall and is high exactly 5800 us; busy low 100 us after echo fall.
REQ-032 trigger high 5 us -> trig_err one-cycle pulse, echo stays 0, busy back to 0.
REQ-033 distance_cm=0, then distance_cm=450 -> echo high 38000 us in both cases; distance_cm=400 -> 23200 us.
REQ-034 distance_cm changed from 10 to 300 during ECHO_HI, plus extra trigger pulses in ECHO_HI/HOLDOFF -> echo width 580 us, single echo pulse only.
REQ-035 reset_p pulsed 1000 us into ECHO_HI -> echo=0 and busy=0 immediately; next valid trigger yields a normal measurement.
REQ-036 trigger held high across HOLDOFF->IDLE -> no new echo until trigger falls and rises again.
